// File: rtl/dmem_access_unit.sv
// Load/store responder: captures one request, runs the mem_resp handshake and aligns/extends data.
// Optional macro DMEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES cycles without mem_resp.
module dmem_access_unit #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall_out,
    output logic [31:0] rdata_out,
    output logic        access_fault,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        fault_q, fault_d;
    logic        is_write_q, is_write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lo_q, lo_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_q, tmo_d;
`endif

    logic        req_any;
    logic        req_ok;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign req_any = req_read | req_write;

    // Write wins when both strobes arrive, so legality is judged against the store encodings.
    always_comb begin
        req_ok    = 1'b0;
        be_new    = 4'b1111;
        wdata_new = wdata;
        if (req_write) begin
            unique case (funct3)
                3'b000: begin
                    req_ok    = 1'b1;
                    be_new    = 4'b0001 << addr[1:0];
                    wdata_new = {4{wdata[7:0]}};
                end
                3'b001: begin
                    req_ok    = ~addr[0];
                    be_new    = 4'b0011 << addr[1:0];
                    wdata_new = {2{wdata[15:0]}};
                end
                3'b010:  req_ok = (addr[1:0] == 2'b00);
                default: req_ok = 1'b0;
            endcase
        end else begin
            unique case (funct3)
                3'b000, 3'b100: req_ok = 1'b1;
                3'b001, 3'b101: req_ok = ~addr[0];
                3'b010:         req_ok = (addr[1:0] == 2'b00);
                default:        req_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        ld_byte = mem_rdata[8*lo_q +: 8];
        ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        // NOTE: every *_d gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        fault_d     = 1'b0;
        is_write_d  = is_write_q;
        funct3_d    = funct3_q;
        lo_d        = lo_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
`ifdef DMEM_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    is_write_d = req_write;
                    funct3_d   = funct3;
                    lo_d       = addr[1:0];
                    addr_d     = {addr[31:2], 2'b00};
                    be_d       = be_new;
                    wdata_d    = wdata_new;
                    if (req_ok) begin
                        mem_read_d  = ~req_write;
                        mem_write_d = req_write;
                        state_d     = S_REQ;
`ifdef DMEM_TIMEOUT_EN
                        tmo_d       = '0;
`endif
                    end else begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    rdata_d     = is_write_q ? '0 : ld_ext;
                    state_d     = S_DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    fault_d     = 1'b1;
                    rdata_d     = '0;
                    state_d     = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            fault_q     <= 1'b0;
            is_write_q  <= 1'b0;
            funct3_q    <= '0;
            lo_q        <= '0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
`ifdef DMEM_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            fault_q     <= fault_d;
            is_write_q  <= is_write_d;
            funct3_q    <= funct3_d;
            lo_q        <= lo_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign stall_out       = (state_q == S_REQ) || ((state_q == S_IDLE) && req_any);
    assign rdata_out       = rdata_q;
    assign access_fault    = fault_q;
    assign mem_address     = addr_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_byte_enable = be_q;
    assign mem_wdata       = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed vector table, hand sequences and randomized accesses
// checked against a size/offset arithmetic reference model.
module tb_dmem_access_unit;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1023;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall_out;
    logic [31:0] rdata_out;
    logic        access_fault;
    logic [31:0] mem_address;
    logic        mem_read, mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .funct3(funct3),
        .addr(addr), .wdata(wdata),
        .stall_out(stall_out), .rdata_out(rdata_out), .access_fault(access_fault),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] md;
        int          delay;
        bit          x_fault;
        logic [3:0]  x_be;
        logic [31:0] x_wd;
        logic [31:0] x_rd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: access size in bytes, legality and lane arithmetic.
    function automatic int sz(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_fault(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || ((a % sz(f3)) != 0);
    endfunction

    function automatic logic [3:0] m_be(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int v;
        if (!wr) return 4'hF;
        v = ((1 << sz(f3)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] md);
        longint v;
        int bits;
        if (sz(f3) == 4) return md;
        bits = 8 * sz(f3);
        v = longint'(md) >> (8 * (a % 4));
        v = v & ((64'd1 << bits) - 1);
        if (!f3[2] && v[bits-1]) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    // Entered and left at a negedge with the DUT idle.
    task automatic do_access(input vec_t v);
        req_read = v.rd; req_write = v.wr; funct3 = v.f3; addr = v.a; wdata = v.wd;
        mem_resp = 1'b0; mem_rdata = $urandom;
        #1;
        check({v.name, " stall_req"}, 32'(stall_out), 32'd1);
        @(negedge clk);
        req_read = 1'b0; req_write = 1'b0;
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (!v.x_fault) begin
            for (int k = 0; k <= v.delay; k++) begin
                check({v.name, " mem_read"}, 32'(mem_read), 32'(v.rd && !v.wr));
                check({v.name, " mem_write"}, 32'(mem_write), 32'(v.wr));
                check({v.name, " mem_address"}, mem_address, v.a & ~32'd3);
                check({v.name, " byte_en"}, 32'(mem_byte_enable), 32'(v.x_be));
                if (v.wr) check({v.name, " mem_wdata"}, mem_wdata, v.x_wd);
                check({v.name, " stall_req_phase"}, 32'(stall_out), 32'd1);
                if (k == v.delay) begin
                    mem_resp = 1'b1; mem_rdata = v.md;
                end else begin
                    mem_rdata = $urandom;
                end
                @(negedge clk);
                mem_resp = 1'b0;
            end
        end
        check({v.name, " done_read"}, 32'(mem_read), 32'd0);
        check({v.name, " done_write"}, 32'(mem_write), 32'd0);
        check({v.name, " done_stall"}, 32'(stall_out), 32'd0);
        check({v.name, " done_fault"}, 32'(access_fault), 32'(v.x_fault));
        if (v.x_fault || !v.wr) check({v.name, " rdata_out"}, rdata_out, v.x_fault ? 32'd0 : v.x_rd);
        mem_resp = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        mem_resp = 1'b0;
        check({v.name, " idle_fault"}, 32'(access_fault), 32'd0);
        check({v.name, " idle_read"}, 32'(mem_read | mem_write), 32'd0);
        check({v.name, " idle_stall"}, 32'(stall_out), 32'd0);
        if (v.x_fault || !v.wr) check({v.name, " idle_rdata_hold"}, rdata_out, v.x_fault ? 32'd0 : v.x_rd);
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst = 1'b1; req_read = 0; req_write = 0; funct3 = 0; addr = 0; wdata = 0;
        mem_rdata = 0; mem_resp = 0;

        //     name      rd wr f3      addr          wdata         mem_rdata     dly flt be      wdata_x       rdata_x
        tbl.push_back('{"LB",     1, 0, 3'b000, 32'h0000_1002, 32'h0,        32'h0080_0000, 2, 0, 4'hF, 32'h0,        32'hFFFF_FF80});
        tbl.push_back('{"SH",     0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,         0, 0, 4'hC, 32'hABCD_ABCD, 32'h0});
        tbl.push_back('{"LW_mis", 1, 0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,         0, 1, 4'h0, 32'h0,        32'h0});
        tbl.push_back('{"SW",     0, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0, 0, 4'hF, 32'hDEAD_BEEF, 32'h0});
        tbl.push_back('{"LHU",    1, 0, 3'b101, 32'h0000_0016, 32'h0,        32'hF00D_0000, 0, 0, 4'hF, 32'h0,        32'h0000_F00D});
        tbl.push_back('{"SB",     0, 1, 3'b000, 32'h0000_0007, 32'h1122_3344, 32'h0,         1, 0, 4'h8, 32'h4444_4444, 32'h0});
        tbl.push_back('{"LBU",    1, 0, 3'b100, 32'h0000_0005, 32'h0,        32'h0000_8000, 0, 0, 4'hF, 32'h0,        32'h0000_0080});
        tbl.push_back('{"LH",     1, 0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_0000, 0, 0, 4'hF, 32'h0,        32'hFFFF_8001});
        tbl.push_back('{"LH_mis", 1, 0, 3'b001, 32'h0000_0001, 32'h0,        32'h0,         0, 1, 4'h0, 32'h0,        32'h0});
        tbl.push_back('{"L_ill",  1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0, 1, 4'h0, 32'h0,        32'h0});
        tbl.push_back('{"S_ill",  0, 1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,         0, 1, 4'h0, 32'h0,        32'h0});
        tbl.push_back('{"RW_ill", 1, 1, 3'b100, 32'h0000_0020, 32'h0,        32'h0,         0, 1, 4'h0, 32'h0,        32'h0});
        tbl.push_back('{"RW_sw",  1, 1, 3'b010, 32'h0000_0020, 32'h5566_7788, 32'h0,         0, 0, 4'hF, 32'h5566_7788, 32'h0});
        tbl.push_back('{"LW_slow",1, 0, 3'b010, 32'h0000_0040, 32'h0,        32'hCAFE_BABE, 5, 0, 4'hF, 32'h0,        32'hCAFE_BABE});

        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_rdata", rdata_out, 32'd0);
        check("rst_fault", 32'(access_fault), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("rst_be", 32'(mem_byte_enable), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) do_access(tbl[i]);

        // Reset while the strobe is up, then a late response must be ignored.
        req_read = 1; funct3 = 3'b010; addr = 32'h0000_0050;
        @(negedge clk);
        req_read = 0;
        check("rstreq_strobe", 32'(mem_read), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstreq_read", 32'(mem_read), 32'd0);
        check("rstreq_addr", mem_address, 32'd0);
        check("rstreq_stall", 32'(stall_out), 32'd0);
        mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_resp = 1'b0;
        check("rstreq_rdata", rdata_out, 32'd0);
        check("rstreq_fault", 32'(access_fault), 32'd0);
        check("rstreq_idle_read", 32'(mem_read), 32'd0);
        rv = '{"post_rst", 1, 0, 3'b010, 32'h0000_0060, 32'h0, 32'h0BAD_F00D, 0, 0, 4'hF, 32'h0, 32'h0BAD_F00D};
        do_access(rv);

        // Long wait without a response.
        req_read = 1; funct3 = 3'b010; addr = 32'h0000_0070;
        @(negedge clk);
        req_read = 0;
`ifdef DMEM_TIMEOUT_EN
        for (int k = 0; k < TO; k++) check("tmo_read_held", 32'(mem_read), 32'd1), @(negedge clk);
        check("tmo_read_drop", 32'(mem_read), 32'd0);
        check("tmo_fault", 32'(access_fault), 32'd1);
        check("tmo_rdata", rdata_out, 32'd0);
        check("tmo_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        check("tmo_fault_clear", 32'(access_fault), 32'd0);
`else
        for (int k = 0; k < 20; k++) begin
            check("wait_read_held", 32'(mem_read), 32'd1);
            check("wait_stall_held", 32'(stall_out), 32'd1);
            @(negedge clk);
        end
        mem_resp = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        mem_resp = 1'b0;
        check("wait_read_drop", 32'(mem_read), 32'd0);
        check("wait_rdata", rdata_out, 32'h1357_9BDF);
        check("wait_fault", 32'(access_fault), 32'd0);
        @(negedge clk);
`endif

        for (int n = 0; n < 60; n++) begin
            rv.name  = "rand";
            rv.wr    = $urandom_range(0, 1);
            rv.rd    = rv.wr ? 1'($urandom_range(0, 1)) : 1'b1;
            rv.f3    = 3'($urandom);
            rv.a     = $urandom;
            rv.wd    = $urandom;
            rv.md    = $urandom;
            rv.delay = $urandom_range(0, 3);
            rv.x_fault = m_fault(rv.wr, rv.f3, rv.a);
            rv.x_be    = m_be(rv.wr, rv.f3, rv.a);
            rv.x_wd    = m_wd(rv.f3, rv.wd);
            rv.x_rd    = m_ld(rv.f3, rv.a, rv.md);
            do_access(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
